side_mid_decoder: RTL and testbench

//  - Inverse of the mid-side encode stage: rebuilds L = M + S and R = M - S from 16-bit signed mid/side.
//  - Streaming block with valid/ready handshakes and a 2-stage pipeline.
//  - Full throughput, output clip detection and a clip event counter.
//  - Sits after the M/S processing chain and feeds the stereo output path.

---
 rtl/side_mid_decoder_if.sv | 38 +++
 rtl/side_mid_decoder.sv | 147 ++++++++++++++
 tb/tb_side_mid_decoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/side_mid_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : side_mid_decoder_if
//  Description : Stream bundle for the mid/side decoder. It carries the input
//                beat (mid/side/enable), the output beat (L/R/clip) and the
//                clip counter signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface side_mid_decoder_if #(
    parameter int DW    = 16,
    parameter int CNT_W = 16
);
    logic             enable;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    mid;
    logic [DW-1:0]    side;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    L_out;
    logic [DW-1:0]    R_out;
    logic             clip;
    logic [CNT_W-1:0] clip_cnt;
    logic             clr_cnt;

    // Upstream/downstream environment side
    modport master (
        output enable, in_valid, mid, side, out_ready, clr_cnt,
        input  in_ready, out_valid, L_out, R_out, clip, clip_cnt
    );

    // Decoder side
    modport slave (
        input  enable, in_valid, mid, side, out_ready, clr_cnt,
        output in_ready, out_valid, L_out, R_out, clip, clip_cnt
    );
endinterface
`default_nettype wire

// File: rtl/side_mid_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : side_mid_decoder
//  Description : Mid/side to left/right decoder, L = M + S, R = M - S, with a
//                two-stage valid/ready pipeline, overflow flag and a
//                saturating clip event counter.
//                Build option MS_DEC_SATURATE_EN: clamp overflowed channels
//                to full scale instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module side_mid_decoder #(
    parameter int DW    = 16,
    parameter int CNT_W = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    side_mid_decoder_if.slave    bus
);

    // Stage 1: widened sum/diff plus the mode captured with the beat
    logic            s1_valid_q, s1_valid_d;
    logic            s1_en_q,    s1_en_d;
    logic [DW:0]     s1_sum_q,   s1_sum_d;
    logic [DW:0]     s1_diff_q,  s1_diff_d;

    // Stage 2: narrowed output beat
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   l_q,         l_d;
    logic [DW-1:0]   r_q,         r_d;
    logic            clip_q,      clip_d;
    logic [CNT_W-1:0] clip_cnt_q, clip_cnt_d;

    logic            s2_load;
    logic            s1_load;
    logic            out_fire;
    logic [DW:0]     mid_x;
    logic [DW:0]     side_x;
    logic            ovf_l;
    logic            ovf_r;
    logic [DW-1:0]   l_nar;
    logic [DW-1:0]   r_nar;

    // Pipeline advance conditions; in_ready depends combinationally on out_ready
    always_comb begin
        s2_load  = !out_valid_q || bus.out_ready;
        s1_load  = !s1_valid_q || s2_load;
        out_fire = out_valid_q && bus.out_ready;
        mid_x    = {bus.mid[DW-1], bus.mid};
        side_x   = {bus.side[DW-1], bus.side};
    end

    // Stage 1 capture: decode mode stores sum/diff, bypass stores mid/side as-is
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_en_d    = s1_en_q;
        s1_sum_d   = s1_sum_q;
        s1_diff_d  = s1_diff_q;
        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_en_d = bus.enable;
                if (bus.enable) begin
                    s1_sum_d  = mid_x + side_x;
                    s1_diff_d = mid_x - side_x;
                end else begin
                    s1_sum_d  = mid_x;
                    s1_diff_d = side_x;
                end
            end
        end
    end

    // Range check and narrowing; bypass values are always in range
    always_comb begin
        ovf_l = s1_en_q && (s1_sum_q[DW]  != s1_sum_q[DW-1]);
        ovf_r = s1_en_q && (s1_diff_q[DW] != s1_diff_q[DW-1]);
`ifdef MS_DEC_SATURATE_EN
        l_nar = ovf_l ? (s1_sum_q[DW]  ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                      : s1_sum_q[DW-1:0];
        r_nar = ovf_r ? (s1_diff_q[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                      : s1_diff_q[DW-1:0];
`else
        l_nar = s1_sum_q[DW-1:0];
        r_nar = s1_diff_q[DW-1:0];
`endif
    end

    // Stage 2 load: output beat holds while stalled
    always_comb begin
        out_valid_d = out_valid_q;
        l_d         = l_q;
        r_d         = r_q;
        clip_d      = clip_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                l_d    = l_nar;
                r_d    = r_nar;
                clip_d = ovf_l | ovf_r;
            end
        end
    end

    // Clip counter: clear wins over a coincident clipped transfer, saturates at all-ones
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (bus.clr_cnt) begin
            clip_cnt_d = '0;
        end else if (out_fire && clip_q && (clip_cnt_q != {CNT_W{1'b1}})) begin
            clip_cnt_d = clip_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous reset discarding any in-flight beats
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_en_q     <= 1'b0;
            s1_sum_q    <= '0;
            s1_diff_q   <= '0;
            out_valid_q <= 1'b0;
            l_q         <= '0;
            r_q         <= '0;
            clip_q      <= 1'b0;
            clip_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_en_q     <= s1_en_d;
            s1_sum_q    <= s1_sum_d;
            s1_diff_q   <= s1_diff_d;
            out_valid_q <= out_valid_d;
            l_q         <= l_d;
            r_q         <= r_d;
            clip_q      <= clip_d;
            clip_cnt_q  <= clip_cnt_d;
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = out_valid_q;
    assign bus.L_out     = l_q;
    assign bus.R_out     = r_q;
    assign bus.clip      = clip_q;
    assign bus.clip_cnt  = clip_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_side_mid_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_side_mid_decoder
//  Description : Self-checking bench for side_mid_decoder: vector table of
//                single beats plus stall, reset, counter-clear and counter
//                saturation sequences. A second instance uses a 4-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_side_mid_decoder;

    typedef struct {
        logic        en;
        logic [15:0] mid;
        logic [15:0] side;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        logic        exp_clip;
    } vec_t;

`ifdef MS_DEC_SATURATE_EN
    localparam logic [15:0] C_V1_L = 16'h7FFF;
    localparam logic [15:0] C_V2_L = 16'h8000;
    localparam logic [15:0] C_V4_R = 16'h7FFF;
    localparam logic [15:0] C_V7_R = 16'h8000;
`else
    localparam logic [15:0] C_V1_L = 16'h8000;
    localparam logic [15:0] C_V2_L = 16'h0000;
    localparam logic [15:0] C_V4_R = 16'hFFFF;
    localparam logic [15:0] C_V7_R = 16'h7FFF;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    side_mid_decoder_if #(.DW(16), .CNT_W(16)) if0 ();
    side_mid_decoder_if #(.DW(16), .CNT_W(4))  if1 ();

    assign if1.enable    = if0.enable;
    assign if1.in_valid  = if0.in_valid;
    assign if1.mid       = if0.mid;
    assign if1.side      = if0.side;
    assign if1.out_ready = if0.out_ready;
    assign if1.clr_cnt   = if0.clr_cnt;

    side_mid_decoder #(.DW(16), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    side_mid_decoder #(.DW(16), .CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One isolated beat: checks latency, data, clip and counter afterwards
    task automatic run_beat(input vec_t v, input string tag);
        int  lat;
        bit  got;
        lat = 0;
        got = 1'b0;
        @(negedge clk);
        if0.enable    = v.en;
        if0.mid       = v.mid;
        if0.side      = v.side;
        if0.in_valid  = 1'b1;
        if0.out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(if0.in_ready), 32'd1);
        for (int n = 1; n <= 8 && !got; n++) begin
            @(negedge clk);
            if (n == 1) if0.in_valid = 1'b0;
            #1;
            if (if0.out_valid) begin
                got = 1'b1;
                lat = n;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'd2);
        if (got) begin
            check({tag, " L_out"}, 32'(if0.L_out), 32'(v.exp_l));
            check({tag, " R_out"}, 32'(if0.R_out), 32'(v.exp_r));
            check({tag, " clip"},  32'(if0.clip),  32'(v.exp_clip));
        end
        if (v.exp_clip) exp_cnt++;
        @(negedge clk);
        #1;
        check({tag, " clip_cnt"},  32'(if0.clip_cnt),  32'(exp_cnt));
        check({tag, " drained"},   32'(if0.out_valid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] got_l [8];
        logic [15:0] got_r [8];
        logic [15:0] hold_l;
        logic [15:0] hold_r;
        bit          holding;
        bit          saw_drop;
        int          sent;
        int          rcv;

        vecs[0] = '{1'b1, 16'd1000, 16'd200, 16'd1200, 16'd800,  1'b0};
        vecs[1] = '{1'b1, 16'h4000, 16'h4000, C_V1_L,  16'h0000, 1'b1};
        vecs[2] = '{1'b1, 16'h8000, 16'h8000, C_V2_L,  16'h0000, 1'b1};
        vecs[3] = '{1'b0, 16'd5,    16'hFFF9, 16'd5,   16'hFFF9, 1'b0};
        vecs[4] = '{1'b1, 16'h7FFF, 16'h8000, 16'hFFFF, C_V4_R,  1'b1};
        vecs[5] = '{1'b1, 16'hFF9C, 16'h012C, 16'h00C8, 16'hFE70, 1'b0};
        vecs[6] = '{1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0};
        vecs[7] = '{1'b1, 16'h8000, 16'h0001, 16'h8001, C_V7_R,  1'b1};

        rst           = 1'b1;
        if0.enable    = 1'b1;
        if0.in_valid  = 1'b0;
        if0.mid       = '0;
        if0.side      = '0;
        if0.out_ready = 1'b1;
        if0.clr_cnt   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset out_valid", 32'(if0.out_valid), 32'd0);
        check("reset in_ready",  32'(if0.in_ready),  32'd1);
        check("reset L_out",     32'(if0.L_out),     32'd0);
        check("reset R_out",     32'(if0.R_out),     32'd0);
        check("reset clip",      32'(if0.clip),      32'd0);
        check("reset clip_cnt",  32'(if0.clip_cnt),  32'd0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            run_beat(vecs[i], $sformatf("vec%0d", i));
        end
        check("table cnt4", 32'(if1.clip_cnt), 32'd4);

        // Back-to-back stream with a 3-cycle downstream stall
        sent     = 0;
        rcv      = 0;
        holding  = 1'b0;
        saw_drop = 1'b0;
        hold_l   = '0;
        hold_r   = '0;
        for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
            @(negedge clk);
            if0.in_valid  = (sent < 8);
            if0.enable    = 1'b1;
            if0.mid       = 16'((sent + 1) * 100);
            if0.side      = 16'(sent + 1);
            if0.out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (holding) begin
                check($sformatf("stall L c%0d", cyc), 32'(if0.L_out), 32'(hold_l));
                check($sformatf("stall R c%0d", cyc), 32'(if0.R_out), 32'(hold_r));
            end
            holding = if0.out_valid && !if0.out_ready;
            hold_l  = if0.L_out;
            hold_r  = if0.R_out;
            if (!if0.in_ready) saw_drop = 1'b1;
            if (if0.out_valid && if0.out_ready) begin
                got_l[rcv] = if0.L_out;
                got_r[rcv] = if0.R_out;
                rcv++;
            end
            if (if0.in_valid && if0.in_ready) sent++;
        end
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        check("stream beats", 32'(rcv), 32'd8);
        check("stream in_ready drop", 32'(saw_drop), 32'd1);
        for (int k = 0; k < rcv && k < 8; k++) begin
            check($sformatf("stream L%0d", k), 32'(got_l[k]), 32'(101 * (k + 1)));
            check($sformatf("stream R%0d", k), 32'(got_r[k]), 32'(99 * (k + 1)));
        end
        repeat (3) @(negedge clk);
        #1;
        check("stream no extra beat", 32'(if0.out_valid), 32'd0);

        // Reset with both stages occupied
        @(negedge clk);
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.enable    = 1'b1;
        if0.mid       = 16'h4000;
        if0.side      = 16'h4000;
        @(negedge clk);
        @(negedge clk);
        if0.in_valid = 1'b0;
        #1;
        check("full out_valid", 32'(if0.out_valid), 32'd1);
        check("full in_ready",  32'(if0.in_ready),  32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if0.out_ready = 1'b1;
        #1;
        exp_cnt = 0;
        check("mid-rst out_valid", 32'(if0.out_valid), 32'd0);
        check("mid-rst in_ready",  32'(if0.in_ready),  32'd1);
        check("mid-rst clip_cnt",  32'(if0.clip_cnt),  32'd0);
        check("mid-rst clip",      32'(if0.clip),      32'd0);
        run_beat(vecs[0], "post-rst");

        // Clear coincident with a clipped transfer
        run_beat(vecs[1], "pre-clr");
        @(negedge clk);
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.enable    = 1'b1;
        if0.mid       = 16'h4000;
        if0.side      = 16'h4000;
        @(negedge clk);
        if0.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("clr held out_valid", 32'(if0.out_valid), 32'd1);
        check("clr held clip",      32'(if0.clip),      32'd1);
        if0.out_ready = 1'b1;
        if0.clr_cnt   = 1'b1;
        @(negedge clk);
        if0.clr_cnt = 1'b0;
        #1;
        exp_cnt = 0;
        check("clr clip_cnt",  32'(if0.clip_cnt),  32'd0);
        check("clr cnt4",      32'(if1.clip_cnt),  32'd0);
        check("clr consumed",  32'(if0.out_valid), 32'd0);

        // Twenty clipped beats back to back: 4-bit counter must stop at 15
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if0.in_valid  = 1'b1;
            if0.out_ready = 1'b1;
            if0.enable    = 1'b1;
            if0.mid       = 16'h8000;
            if0.side      = 16'h8000;
        end
        @(negedge clk);
        if0.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        exp_cnt = exp_cnt + 20;
        check("sat cnt16", 32'(if0.clip_cnt), 32'(exp_cnt));
        check("sat cnt4",  32'(if1.clip_cnt), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
